// File: rtl/qspi_fetch_ctrl_pkg.sv
// Shared types for the QSPI cartridge-ROM fetch controller.
// Frame states and per-state nibble counts.
package qspi_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        STREAM,
        DESEL
    } state_t;

    localparam int CNT_W = 4;

    localparam logic [7:0] READ_CMD_DEF = 8'hEB;

    localparam logic [CNT_W-1:0] CMD_NIBBLES  = CNT_W'(2);
    localparam logic [CNT_W-1:0] ADDR_NIBBLES = CNT_W'(6);
    localparam logic [CNT_W-1:0] DATA_NIBBLES = CNT_W'(2);

    function automatic logic [CNT_W-1:0] nibbles_for(
        input state_t           s,
        input logic [CNT_W-1:0] dummy
    );
        case (s)
            CMD:     return CMD_NIBBLES;
            ADDR:    return ADDR_NIBBLES;
            DUMMY:   return dummy;
            DATA:    return DATA_NIBBLES;
            default: return CNT_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/qspi_sclk_phase.sv
// sclk phase toggle and per-state nibble down-counter.
// Each nibble is one A/B pair of system clocks.
module qspi_sclk_phase
    import qspi_fetch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] load_count,
    output logic             phase_a,
    output logic             phase_b,
    output logic             last_nibble
);

    logic             ph;
    logic [CNT_W-1:0] cnt;

    // A load always restarts in phase A of the first nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph  <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            ph  <= 1'b0;
            cnt <= load_count - 1'b1;
        end else if (run) begin
            ph <= ~ph;
            if (ph && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign phase_a     = run & ~ph;
    assign phase_b     = run & ph;
    assign last_nibble = (cnt == '0);

endmodule

// File: rtl/qspi_fetch_ctrl.sv
// QSPI flash fetch controller for the cartridge ROM port.
// Streams sequential bytes without reselecting the flash.
module qspi_fetch_ctrl
    import qspi_fetch_ctrl_pkg::*;
#(
    parameter logic [7:0] READ_CMD     = READ_CMD_DEF,
    parameter int         DUMMY_CYCLES = 4,
    parameter int         CS_HIGH_CLKS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        stall,
    output logic        spi_select,
    output logic        spi_sclk,
    output logic [3:0]  spi_io_out,
    output logic [3:0]  spi_io_oe,
    input  logic [3:0]  spi_io_in
);

    localparam int DW =
        (CS_HIGH_CLKS > 1) ? $clog2(CS_HIGH_CLKS) : 1;

    localparam logic [DW-1:0] DESEL_LAST =
        DW'(CS_HIGH_CLKS - 1);

    localparam logic [CNT_W-1:0] DUMMY_N =
        CNT_W'(DUMMY_CYCLES);

    state_t           state;
    state_t           state_nx;
    logic             ready_en;
    logic             data_done;
    logic             accept;
    logic             seq_hit;
    logic             run;
    logic             load;
    logic [CNT_W-1:0] load_count;
    logic             phase_a;
    logic             phase_b;
    logic             last_nibble;
    logic             step_end;
    logic [DW-1:0]    desel_cnt;
    logic [23:0]      addr_q;
    logic [23:0]      next_addr;
    logic             next_valid;
    logic [31:0]      tx_sr;
    logic [7:0]       rx_sr;

    assign accept = req_valid & req_ready;

    // Address zero never qualifies, so a 24-bit wrap reselects.
    assign seq_hit = next_valid
                   && (req_addr == next_addr)
                   && (next_addr != '0);

    assign run = (state inside {CMD, ADDR, DUMMY, DATA})
               && !data_done;

    assign step_end   = phase_b & last_nibble;
    assign load       = (state_nx != state);
    assign load_count = nibbles_for(state_nx, DUMMY_N);

    qspi_sclk_phase u_phase (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .load        (load),
        .load_count  (load_count),
        .phase_a     (phase_a),
        .phase_b     (phase_b),
        .last_nibble (last_nibble)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = CMD;
            end
            CMD: begin
                if (step_end) state_nx = ADDR;
            end
            ADDR: begin
                if (step_end) state_nx = DUMMY;
            end
            DUMMY: begin
                if (step_end) state_nx = DATA;
            end
            DATA: begin
                if (data_done) state_nx = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    state_nx = seq_hit ? DATA : DESEL;
                end
            end
            DESEL: begin
                if (desel_cnt == '0) state_nx = CMD;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        spi_select = 1'b1;
        spi_io_oe  = 4'h0;
        spi_io_out = 4'h0;
        req_ready  = 1'b0;
        unique case (1'b1)
            (state == IDLE): begin
                req_ready = ready_en;
            end
            (state == CMD),
            (state == ADDR): begin
                spi_select = 1'b0;
                spi_io_oe  = 4'hF;
                spi_io_out = tx_sr[31:28];
            end
            (state == DUMMY),
            (state == DATA): begin
                spi_select = 1'b0;
            end
            (state == STREAM): begin
                spi_select = 1'b0;
                req_ready  = ready_en;
            end
            default: begin
            end
        endcase
    end

    assign spi_sclk = phase_b;

    assign stall = phase_a
                 | phase_b
                 | data_done
                 | (state == DESEL)
                 | rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            data_done  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'h00;
            addr_q     <= '0;
            next_addr  <= '0;
            next_valid <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            desel_cnt  <= '0;
        end else begin
            ready_en  <= 1'b1;
            rsp_valid <= 1'b0;

            if (accept) begin
                addr_q <= req_addr;
            end

            // From IDLE the address has not reached addr_q yet.
            if (load && state_nx == CMD) begin
                tx_sr <= {READ_CMD,
                          (state == IDLE) ? req_addr : addr_q};
            end else if (phase_b
                         && (state == CMD || state == ADDR)) begin
                tx_sr <= {tx_sr[27:0], 4'h0};
            end

            if (phase_b && state == DATA) begin
                rx_sr <= {rx_sr[3:0], spi_io_in};
            end

            data_done <= (state == DATA) && step_end;

            if (state == DATA && data_done) begin
                rsp_valid  <= 1'b1;
                rsp_data   <= rx_sr;
                next_addr  <= addr_q + 24'd1;
                next_valid <= 1'b1;
            end

            if (state_nx == DESEL && state != DESEL) begin
                desel_cnt <= DESEL_LAST;
            end else if (state == DESEL && desel_cnt != '0) begin
                desel_cnt <= desel_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qspi_fetch_ctrl.sv
// Bench for qspi_fetch_ctrl: directed table, random stream, reset.
// A behavioural flash model answers on the QSPI pins.
module tb_qspi_fetch_ctrl;

    localparam int D         = 4;
    localparam int CSH       = 2;
    localparam int LAT_FRESH = 2 * (10 + D) + 1;
    localparam int LAT_SEQ   = 5;
    localparam int LAT_JUMP  = CSH + LAT_FRESH;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic [23:0] req_addr  = 24'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        stall;
    logic        spi_select;
    logic        spi_sclk;
    logic [3:0]  spi_io_out;
    logic [3:0]  spi_io_oe;
    logic [3:0]  spi_io_in = 4'h0;

    int n_pass  = 0;
    int n_total = 0;

    qspi_fetch_ctrl #(
        .READ_CMD     (8'hEB),
        .DUMMY_CYCLES (D),
        .CS_HIGH_CLKS (CSH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .stall      (stall),
        .spi_select (spi_select),
        .spi_sclk   (spi_sclk),
        .spi_io_out (spi_io_out),
        .spi_io_oe  (spi_io_oe),
        .spi_io_in  (spi_io_in)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [23:0] a);
        if (a == 24'h000123) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h3C;
    endfunction

    // Flash model: 8 cmd/addr nibbles in, D dummies, then bytes out.
    int          rises      = 0;
    int          frames     = 0;
    int          oe_bad     = 0;
    logic [31:0] sh         = 32'h0;
    logic [31:0] frame_word = 32'h0;
    logic [23:0] faddr      = 24'h0;

    always @(posedge spi_sclk or posedge spi_select) begin
        if (spi_select) begin
            rises = 0;
        end else begin
            if (rises < 8) begin
                sh = {sh[27:0], spi_io_out};
                if (spi_io_oe != 4'hF) oe_bad++;
            end else if (spi_io_oe != 4'h0) begin
                oe_bad++;
            end
            rises++;
            if (rises == 8) begin
                frame_word = sh;
                faddr      = sh[23:0];
                frames++;
            end
        end
    end

    always @(negedge spi_sclk) begin
        int         idx;
        logic [7:0] b;
        if (!spi_select && rises >= 8 + D) begin
            idx = rises - 8 - D;
            b   = mem(faddr + 24'(idx / 2));
            spi_io_in <= idx[0] ? b[3:0] : b[7:4];
        end
    end

    int hi_cnt   = 0;
    int last_gap = 0;

    always @(negedge clk) begin
        if (spi_select) begin
            hi_cnt++;
        end else if (hi_cnt != 0) begin
            last_gap = hi_cnt;
            hi_cnt   = 0;
        end
    end

    // Reference model state
    bit          streaming = 1'b0;
    logic [23:0] last_addr = 24'h0;
    logic [7:0]  prev_data = 8'h00;

    function automatic int model_lat(input logic [23:0] a);
        logic [23:0] nxt;
        nxt = last_addr + 24'd1;
        if (!streaming) return LAT_FRESH;
        if (a == nxt && nxt != 24'h0) return LAT_SEQ;
        return LAT_JUMP;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      name, act, exp);
    endtask

    task automatic do_req(input logic [23:0] a,
                          input bit noise,
                          input int exp_lat,
                          input logic [7:0] exp_d,
                          input string tag);
        int lat;
        int w;
        int f0;
        bit got;
        bit st_ok;
        req_valid = 1'b1;
        req_addr  = a;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        f0 = frames;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, " pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, " hold"}, 32'(rsp_data), 32'(prev_data));
        lat   = 0;
        got   = 1'b0;
        st_ok = 1'b1;
        while (!got && lat < 200) begin
            if (!stall) st_ok = 1'b0;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                req_valid = noise && lat < 2;
                req_addr  = 24'($urandom);
                @(negedge clk);
                lat++;
            end
        end
        req_valid = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " data"}, 32'(rsp_data), 32'(exp_d));
        chk({tag, " stall"}, 32'(st_ok), 32'd1);
        if (exp_lat == LAT_SEQ) begin
            chk({tag, " no frame"}, 32'(frames), 32'(f0));
        end else begin
            chk({tag, " frame"}, 32'(frames), 32'(f0 + 1));
            chk({tag, " cmdaddr"}, frame_word, {8'hEB, a});
        end
        if (exp_lat == LAT_JUMP) begin
            chk({tag, " desel gap"}, 32'(last_gap), 32'(CSH));
        end
        streaming = 1'b1;
        last_addr = a;
        prev_data = exp_d;
    endtask

    typedef struct {
        logic [23:0] addr;
        int          lat;
        logic [7:0]  data;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [23:0] a;
        int          w;
        bit          got;

        tbl[0] = '{24'h000123, LAT_FRESH, 8'hA5};
        tbl[1] = '{24'h000124, LAT_SEQ,   mem(24'h000124)};
        tbl[2] = '{24'h000800, LAT_JUMP,  mem(24'h000800)};
        tbl[3] = '{24'h000801, LAT_SEQ,   mem(24'h000801)};
        tbl[4] = '{24'hFFFFFF, LAT_JUMP,  mem(24'hFFFFFF)};
        tbl[5] = '{24'h000000, LAT_JUMP,  mem(24'h000000)};
        tbl[6] = '{24'h000001, LAT_SEQ,   mem(24'h000001)};

        repeat (3) @(negedge clk);
        chk("rst select", 32'(spi_select), 32'd1);
        chk("rst sclk", 32'(spi_sclk), 32'd0);
        chk("rst oe", 32'(spi_io_oe), 32'd0);
        chk("rst io_out", 32'(spi_io_out), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_data", 32'(rsp_data), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after rst", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            do_req(tbl[i].addr, 1'b0, tbl[i].lat,
                   tbl[i].data, $sformatf("vec%0d", i));
        end
        chk("stream select", 32'(spi_select), 32'd0);

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5)       a = last_addr + 24'd1;
            else if (r == 5) a = 24'hFFFFFF;
            else if (r == 6) a = 24'h000000;
            else             a = 24'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_req(a, bit'($urandom_range(0, 1)),
                   model_lat(a), mem(a), "rnd");
        end

        a = last_addr + 24'h10;
        req_valid = 1'b1;
        req_addr  = a;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (rises < 10 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("mid select", 32'(spi_select), 32'd0);
        chk("mid dummy oe", 32'(spi_io_oe), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async select", 32'(spi_select), 32'd1);
        chk("async sclk", 32'(spi_sclk), 32'd0);
        chk("async ready", 32'(req_ready), 32'd0);
        got = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after rst2", 32'(req_ready), 32'd1);
        repeat (5) begin
            if (rsp_valid) got = 1'b1;
            @(negedge clk);
        end
        chk("no rsp abandoned", 32'(got), 32'd0);
        streaming = 1'b0;
        prev_data = 8'h00;
        do_req(24'h00BEEF, 1'b0, LAT_FRESH,
               mem(24'h00BEEF), "post rst");

        chk("oe discipline", 32'(oe_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
